mem_write_checker: RTL
======================

MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter WIDTH, default 32: width of monitored address and data buses.
REQ-002 Parameter DEPTH, default 4: maximum entries in the expected-write table.
REQ-003 Parameter TIMEOUT, default 1000: RUN-state cycle budget before a timeout failure.
REQ-004 Parameter SCRATCH_ADR, default 96: address whose writes are tolerated, non-matching.
REQ-005 Clock and reset SHALL be: clk input 1, single clock, all state updates on rising edge; reset input 1, synchronous, active-low.
REQ-006 start input 1: one-cycle pulse, IDLE -> RUN.
REQ-007 num_exp input $clog2(DEPTH+1): expected writes to match (1..DEPTH), sampled on start.
REQ-008 cfg_we input 1: table write strobe, honoured only in IDLE.
REQ-009 cfg_idx input $clog2(DEPTH): table entry index.
REQ-010 cfg_adr, cfg_data input WIDTH each: expected address/data for entry cfg_idx.
REQ-011 MemWrite input 1: monitored bus write strobe.
REQ-012 DataAdr, WriteData input WIDTH each: monitored write address/data.
REQ-013 busy output 1: high in RUN.
REQ-014 done output 1: high in PASS or FAIL.
REQ-015 pass output 1: high in PASS only.
REQ-016 fail_code output 2: 00 none, 01 mismatch, 10 timeout, 11 bad num_exp.
REQ-017 match_count output $clog2(DEPTH+1): entries matched so far.
REQ-018 fail_adr, fail_data output WIDTH each: offending write captured on mismatch.

Function
REQ-019 FSM SHALL have states IDLE, RUN, PASS, FAIL; all outputs registered, visible the cycle after the deciding edge.
REQ-020 IDLE: start with num_exp in 1..DEPTH -> RUN, clear match_count and timeout counter; start with num_exp 0 or >DEPTH -> FAIL, fail_code 11.
REQ-021 RUN, MemWrite high, DataAdr/WriteData equal entry[match_count] (full-width compare, === semantics, X/Z never matches) -> match_count+1.
REQ-022 Match of final entry (match_count == num_exp-1) -> PASS.
REQ-023 RUN, MemWrite high, no match, not scratch-tolerated (REQ-030) -> FAIL, fail_code 01, capture DataAdr/WriteData.
REQ-024 RUN, MemWrite low -> no change except timeout counter.
REQ-025 Timeout counter increments each RUN cycle; at TIMEOUT-1 with no deciding write -> FAIL, fail_code 10.
REQ-026 Same-cycle write decision and timeout: write result (PASS or mismatch) SHALL win.
REQ-027 PASS/FAIL sticky; start there -> RUN with fresh counters, outputs cleared; start ignored in RUN.
REQ-028 cfg_we outside IDLE SHALL be ignored; table contents survive PASS/FAIL/start.

Reset
REQ-029 reset low at rising edge: state IDLE, busy/done/pass 0, fail_code 00, match_count 0, fail_adr/fail_data 0, timeout counter 0; table contents need not be cleared; reset mid-RUN aborts without reporting.

Configuration
REQ-030 Macro CHECKER_SCRATCH_EN: defined -> non-matching writes with DataAdr == SCRATCH_ADR ignored in RUN; undefined -> such writes fail as REQ-023.

Verification
REQ-031 Table {(100,25)}, num_exp 1, start, writes (96,7),(100,25) -> with macro: pass 1, match_count 1; without: FAIL 01, fail_adr 96, fail_data 7.
REQ-032 Table {(100,25)}, write (100,24) -> FAIL 01, fail_adr 100, fail_data 24, pass 0.
REQ-033 Table {(8,1),(12,2),(16,3)}, num_exp 3, in-order writes -> match_count 1,2 then PASS; (12,2) first -> FAIL 01.
REQ-034 TIMEOUT 50, no MemWrite after start -> done 1, fail_code 10 exactly 50 cycles after start; matching write in that cycle -> PASS.
REQ-035 num_exp 0 start -> FAIL 11 next cycle; reset low mid-RUN -> all outputs 0, IDLE, next start runs normally.

Source files
------------

// File: rtl/mem_write_checker.sv
// Monitors a memory write bus against a small table of expected (address, data) writes.
// Optional CHECKER_SCRATCH_EN: non-matching writes to SCRATCH_ADR are tolerated while running.
module mem_write_checker #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned SCRATCH_ADR = 96,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CW-1:0]    num_exp,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [WIDTH-1:0] cfg_adr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             MemWrite,
    input  logic [WIDTH-1:0] DataAdr,
    input  logic [WIDTH-1:0] WriteData,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CW-1:0]    match_count,
    output logic [WIDTH-1:0] fail_adr,
    output logic [WIDTH-1:0] fail_data
);

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISMATCH = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_BADNUM   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t           state;
    logic [CW-1:0]    num_q;
    logic [TW-1:0]    tcnt;
    logic [WIDTH-1:0] tbl_adr  [DEPTH];
    logic [WIDTH-1:0] tbl_data [DEPTH];

    logic             hit;
    logic             last;
    logic             scratch;
    logic             num_ok;
    logic             tmo;

    // Expected-write table; writable only while idle, deliberately not reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && cfg_we) begin
            tbl_adr[cfg_idx]  <= cfg_adr;
            tbl_data[cfg_idx] <= cfg_data;
        end
    end

    // Match/decision terms for the current bus cycle.
    always_comb begin
        hit     = 1'b0;
        last    = 1'b0;
        scratch = 1'b0;
        num_ok  = (num_exp != CW'(0)) && (num_exp <= CW'(DEPTH));
        tmo     = (tcnt == TW'(TIMEOUT - 1));
        if (MemWrite && (DataAdr === tbl_adr[IW'(match_count)])
                     && (WriteData === tbl_data[IW'(match_count)])) begin
            hit = 1'b1;
        end
        last = (match_count == (num_q - CW'(1)));
`ifdef CHECKER_SCRATCH_EN
        scratch = (DataAdr == WIDTH'(SCRATCH_ADR));
`else
        scratch = 1'b0;
`endif
    end

    // Checker FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FC_NONE;
            match_count <= '0;
            fail_adr    <= '0;
            fail_data   <= '0;
            tcnt        <= '0;
            num_q       <= '0;
        end else begin
            case (state)
                S_IDLE, S_PASS, S_FAIL: begin
                    if (start) begin
                        match_count <= '0;
                        tcnt        <= '0;
                        fail_adr    <= '0;
                        fail_data   <= '0;
                        pass        <= 1'b0;
                        if (num_ok) begin
                            state     <= S_RUN;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            fail_code <= FC_NONE;
                            num_q     <= num_exp;
                        end else begin
                            state     <= S_FAIL;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            fail_code <= FC_BADNUM;
                        end
                    end
                end
                S_RUN: begin
                    // A deciding write (final match or mismatch) takes priority over timeout.
                    if (hit && last) begin
                        match_count <= match_count + CW'(1);
                        state       <= S_PASS;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        pass        <= 1'b1;
                    end else if (MemWrite && !hit && !scratch) begin
                        state     <= S_FAIL;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        fail_code <= FC_MISMATCH;
                        fail_adr  <= DataAdr;
                        fail_data <= WriteData;
                    end else begin
                        if (hit) begin
                            match_count <= match_count + CW'(1);
                        end
                        if (tmo) begin
                            state     <= S_FAIL;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            fail_code <= FC_TIMEOUT;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
